// File: rtl/mm_pkg.sv
// mm_pkg: shared types and parameters for the tile-level matrix-multiply scheduler.
//   T, W, ACCW, CNTW : tile edge, A/B element width, C element width, tile counter width
//   mm_op_e          : datapath command opcode
//   mm_sched_state_e : scheduler FSM states
//   regs_t           : job configuration from the register block
//   mm_cmd_t         : one command presented to the datapath
package mm_pkg;

    localparam int unsigned T    = 16;
    localparam int unsigned W    = 8;    // multiple of 8
    localparam int unsigned ACCW = 32;   // multiple of 8
    localparam int unsigned CNTW = 16;
    localparam int unsigned AW   = 32;
    localparam int unsigned LDW  = 16;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        STORE_C = 2'd3
    } mm_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } mm_sched_state_e;

    typedef struct packed {
        logic [AW-1:0]   base_a;
        logic [AW-1:0]   base_b;
        logic [AW-1:0]   base_c;
        logic [LDW-1:0]  lda;
        logic [LDW-1:0]  ldb;
        logic [LDW-1:0]  ldc;
        logic [CNTW-1:0] tiles_k;
        logic            irq_en;
    } regs_t;

    typedef struct packed {
        mm_op_e         op;
        logic [AW-1:0]  addr;
        logic [LDW-1:0] ld;
        logic           acc_clr;
    } mm_cmd_t;

    // Byte offset of tile (row, col): (row*T*ld + col*T) * bytes, modulo 2^32.
    function automatic logic [AW-1:0] tile_offset(
        input logic [CNTW-1:0] row,
        input logic [LDW-1:0]  ld,
        input logic [CNTW-1:0] col,
        input logic [AW-1:0]   bytes
    );
        logic [AW-1:0] elems;
        elems = AW'(row) * AW'(T) * AW'(ld) + AW'(col) * AW'(T);
        return elems * bytes;
    endfunction

endpackage

// File: rtl/mm_tile_addr_gen.sv
// mm_tile_addr_gen: combinational tile address / leading-dimension selector.
//   op_i              : current command opcode
//   i_i, j_i, k_i     : tile counters
//   base_*_i, ld*_i   : shadowed job configuration
//   addr_o            : tile byte address (0 for COMPUTE)
//   ld_o              : leading dimension in elements (0 for COMPUTE)
module mm_tile_addr_gen
    import mm_pkg::*;
(
    input  mm_op_e          op_i,
    input  logic [CNTW-1:0] i_i,
    input  logic [CNTW-1:0] j_i,
    input  logic [CNTW-1:0] k_i,
    input  logic [AW-1:0]   base_a_i,
    input  logic [AW-1:0]   base_b_i,
    input  logic [AW-1:0]   base_c_i,
    input  logic [LDW-1:0]  lda_i,
    input  logic [LDW-1:0]  ldb_i,
    input  logic [LDW-1:0]  ldc_i,
    output logic [AW-1:0]   addr_o,
    output logic [LDW-1:0]  ld_o
);

    localparam logic [AW-1:0] AB_BYTES = AW'(W / 8);
    localparam logic [AW-1:0] C_BYTES  = AW'(ACCW / 8);

    always_comb begin
        addr_o = '0;
        ld_o   = '0;
        case (op_i)
            LOAD_A: begin
                addr_o = base_a_i + tile_offset(i_i, lda_i, k_i, AB_BYTES);
                ld_o   = lda_i;
            end
            LOAD_B: begin
                addr_o = base_b_i + tile_offset(k_i, ldb_i, j_i, AB_BYTES);
                ld_o   = ldb_i;
            end
            STORE_C: begin
                addr_o = base_c_i + tile_offset(i_i, ldc_i, j_i, C_BYTES);
                ld_o   = ldc_i;
            end
            default: begin
                addr_o = '0;
                ld_o   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mm_tile_sched.sv
// mm_tile_sched: walks all output tiles (i outer, j middle, k inner) and issues a
// strictly serial LOAD_A / LOAD_B / COMPUTE / STORE_C command stream.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : one-cycle job start / cancel pulses
//   cfg               : job configuration, captured on the start cycle
//   cmd_valid/ready   : command handshake; cmd_op/addr/ld/acc_clr are the fields
//   cmd_done          : accepted command finished
//   busy, done, irq   : job in progress, end-of-job pulse, sticky interrupt
//   irq_clr           : clears irq
//
// state   | meaning
// --------+----------------------------------------------------
// S_IDLE  | no job; waiting for start
// S_ISSUE | command presented, waiting for cmd_ready
// S_WAIT  | command accepted, waiting for cmd_done
// S_DONE  | one-cycle end-of-job pulse
module mm_tile_sched
    import mm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  regs_t       cfg,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [31:0] cmd_addr,
    output logic [15:0] cmd_ld,
    output logic        cmd_acc_clr,
    input  logic        cmd_done,
    output logic        busy,
    output logic        done,
    output logic        irq,
    input  logic        irq_clr
);

    mm_sched_state_e state_q, state_d;
    mm_op_e          op_q, op_d;
    logic [CNTW-1:0] i_q, i_d;
    logic [CNTW-1:0] j_q, j_d;
    logic [CNTW-1:0] k_q, k_d;
    regs_t           cfg_q, cfg_d;
    logic            irq_q, irq_d;

    logic [CNTW-1:0] last_idx;
    logic [AW-1:0]   tile_addr;
    logic [LDW-1:0]  tile_ld;
    mm_cmd_t         cmd;

    // Only meaningful while a job runs, and jobs with tiles_k == 0 never leave S_IDLE
    // for S_ISSUE, so the wrap at tiles_k == 0 is harmless.
    assign last_idx = cfg_q.tiles_k - CNTW'(1);

    mm_tile_addr_gen u_addr_gen (
        .op_i     (op_q),
        .i_i      (i_q),
        .j_i      (j_q),
        .k_i      (k_q),
        .base_a_i (cfg_q.base_a),
        .base_b_i (cfg_q.base_b),
        .base_c_i (cfg_q.base_c),
        .lda_i    (cfg_q.lda),
        .ldb_i    (cfg_q.ldb),
        .ldc_i    (cfg_q.ldc),
        .addr_o   (tile_addr),
        .ld_o     (tile_ld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= LOAD_A;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            cfg_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            cfg_q   <= cfg_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        cfg_d   = cfg_q;

        if (abort) begin
            state_d = S_IDLE;
            op_d    = LOAD_A;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cfg_d   = cfg;
                        op_d    = LOAD_A;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        state_d = (cfg.tiles_k == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cmd_done) begin
                        state_d = S_ISSUE;
                        case (op_q)
                            LOAD_A:  op_d = LOAD_B;
                            LOAD_B:  op_d = COMPUTE;
                            COMPUTE: begin
                                if (k_q != last_idx) begin
                                    k_d  = k_q + CNTW'(1);
                                    op_d = LOAD_A;
                                end else begin
                                    op_d = STORE_C;
                                end
                            end
                            default: begin
                                // STORE_C closes tile (i,j): advance j, carrying into i.
                                k_d  = '0;
                                op_d = LOAD_A;
                                if (j_q != last_idx) begin
                                    j_d = j_q + CNTW'(1);
                                end else begin
                                    j_d = '0;
                                    if (i_q != last_idx) begin
                                        i_d = i_q + CNTW'(1);
                                    end else begin
                                        i_d     = '0;
                                        state_d = S_DONE;
                                    end
                                end
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Fields are forced to zero outside S_ISSUE so idle outputs read as reset values.
    always_comb begin
        cmd.op      = LOAD_A;
        cmd.addr    = '0;
        cmd.ld      = '0;
        cmd.acc_clr = 1'b0;
        if (state_q == S_ISSUE) begin
            cmd.op      = op_q;
            cmd.addr    = tile_addr;
            cmd.ld      = tile_ld;
            cmd.acc_clr = (op_q == COMPUTE) && (k_q == '0);
        end
    end

    // Abort masks valid and done in its own cycle so no handshake or completion
    // is reported for a job that is being cancelled.
    assign cmd_valid   = (state_q == S_ISSUE) && !abort;
    assign cmd_op      = cmd.op;
    assign cmd_addr    = cmd.addr;
    assign cmd_ld      = cmd.ld;
    assign cmd_acc_clr = cmd.acc_clr;
    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done        = (state_q == S_DONE) && !abort;

    // Set has priority over clear.
    always_comb begin
        irq_d = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (done && cfg_q.irq_en) begin
            irq_d = 1'b1;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_mm_tile_sched.sv
`timescale 1ns/1ps
module tb_mm_tile_sched;
    import mm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    regs_t       cfg = '0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_ld;
    logic        cmd_acc_clr;
    logic        cmd_done = 1'b0;
    logic        busy, done, irq;
    logic        irq_clr = 1'b0;

    always #5 clk = ~clk;

    mm_tile_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg(cfg),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_ld(cmd_ld), .cmd_acc_clr(cmd_acc_clr),
        .cmd_done(cmd_done), .busy(busy), .done(done), .irq(irq), .irq_clr(irq_clr)
    );

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [15:0] ld;
        bit          acc_clr;
    } exp_t;

    exp_t exp_q[$];
    exp_t acc_log[$];

    int n_cmp = 0;
    int n_err = 0;
    int op_cnt[4];
    int clr_cnt, done_cnt, valid_cnt, stall_cnt;

    bit rdy_rand    = 1'b0;
    bit stall_b_arm = 1'b0;
    int stall_left  = 0;
    int dly_min     = 2;
    int dly_max     = 2;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- reference model: plain loop nest over the tile grid
    function automatic logic [31:0] offs(input longint unsigned row, input longint unsigned ld,
                                         input longint unsigned col, input longint unsigned bytes);
        longint unsigned v;
        v = (row * T * ld + col * T) * bytes;
        return v[31:0];
    endfunction

    task automatic model_job(input regs_t c);
        int n;
        exp_t e;
        n = int'(c.tiles_k);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                for (int k = 0; k < n; k++) begin
                    e.op = 0; e.addr = c.base_a + offs(i, c.lda, k, W / 8); e.ld = c.lda; e.acc_clr = 0;
                    exp_q.push_back(e);
                    e.op = 1; e.addr = c.base_b + offs(k, c.ldb, j, W / 8); e.ld = c.ldb; e.acc_clr = 0;
                    exp_q.push_back(e);
                    e.op = 2; e.addr = 32'h0; e.ld = 16'h0; e.acc_clr = (k == 0);
                    exp_q.push_back(e);
                end
                e.op = 3; e.addr = c.base_c + offs(i, c.ldc, j, ACCW / 8); e.ld = c.ldc; e.acc_clr = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    // ---------------- monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_cmd: actual op %0d addr 0x%0h, required no command", cmd_op, cmd_addr);
                end else begin
                    chk("cmd_op", longint'(cmd_op), longint'(exp_q[0].op));
                    if (exp_q[0].op != 2) chk("cmd_addr", longint'(cmd_addr), longint'(exp_q[0].addr));
                    chk("cmd_ld", longint'(cmd_ld), longint'(exp_q[0].ld));
                    chk("cmd_acc_clr", longint'(cmd_acc_clr), longint'(exp_q[0].acc_clr));
                    if (cmd_ready) begin
                        exp_t a;
                        a.op = int'(cmd_op); a.addr = cmd_addr; a.ld = cmd_ld; a.acc_clr = cmd_acc_clr;
                        acc_log.push_back(a);
                        op_cnt[cmd_op]++;
                        if (cmd_acc_clr) clr_cnt++;
                        void'(exp_q.pop_front());
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- datapath responder: cmd_done some cycles after accept
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (cmd_valid && cmd_ready && rst_n) begin
                d = $urandom_range(dly_max, dly_min);
                repeat (d) @(posedge clk);
                #1 cmd_done = 1'b1;
                @(posedge clk);
                #1 cmd_done = 1'b0;
            end
        end
    end

    // ---------------- cmd_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                cmd_ready = 1'b0;
                stall_left--;
            end else if (stall_b_arm && cmd_valid && cmd_op == 2'd1) begin
                cmd_ready   = 1'b0;
                stall_left  = 9;
                stall_b_arm = 1'b0;
            end else if (rdy_rand) begin
                cmd_ready = ($urandom_range(0, 3) != 0);
            end else begin
                cmd_ready = 1'b1;
            end
        end
    end

    function automatic regs_t mk(input int n, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [15:0] la,
                                 input logic [15:0] lb, input logic [15:0] lc, input bit ie);
        regs_t r;
        r.base_a = a; r.base_b = b; r.base_c = c;
        r.lda = la; r.ldb = lb; r.ldc = lc;
        r.tiles_k = 16'(n); r.irq_en = ie;
        return r;
    endfunction

    function automatic regs_t rnd_cfg(input int n, input bit ie);
        return mk(n, $urandom, $urandom, $urandom, 16'($urandom), 16'($urandom), 16'($urandom), ie);
    endfunction

    task automatic start_job(input regs_t c);
        foreach (op_cnt[x]) op_cnt[x] = 0;
        clr_cnt = 0; done_cnt = 0; valid_cnt = 0; stall_cnt = 0;
        exp_q.delete();
        acc_log.delete();
        model_job(c);
        @(posedge clk);
        #1 cfg = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cfg = rnd_cfg(int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    endtask

    task automatic pulse_irq_clr();
        @(posedge clk); #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
    endtask

    task automatic run_job(input regs_t c, input bit mid_start, input bit clr_at_done, input bit exp_irq);
        int n;
        int budget;
        int cyc;
        bit seen;
        n = int'(c.tiles_k);
        budget = 16 * (3 * n * n * n + n * n) + 60;
        start_job(c);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && n > 0) chk("busy_after_start", busy, 1);
            if (mid_start && cyc == 20) start = 1'b1;
            if (cyc == 21) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                if (clr_at_done) irq_clr = 1'b1;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        if (n == 0) begin
            chk("zero_job_done_latency_le2", (cyc <= 2), 1);
            chk("zero_job_valid_cycles", valid_cnt, 0);
        end
        @(posedge clk);
        #1 irq_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("busy_after_done", busy, 0);
        chk("cmds_left", exp_q.size(), 0);
        chk("cnt_load_a", op_cnt[0], n * n * n);
        chk("cnt_load_b", op_cnt[1], n * n * n);
        chk("cnt_compute", op_cnt[2], n * n * n);
        chk("cnt_store_c", op_cnt[3], n * n);
        chk("cnt_acc_clr", clr_cnt, n * n);
        chk("irq_after_job", irq, exp_irq);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, cmd_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_irq"}, irq, 0);
        chk({tag, "_op"}, cmd_op, 0);
        chk({tag, "_addr"}, cmd_addr, 0);
        chk({tag, "_ld"}, cmd_ld, 0);
        chk({tag, "_clr"}, cmd_acc_clr, 0);
    endtask

    initial begin
        regs_t c;
        int cyc;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // single tile, fixed 2-cycle completion
        dly_min = 2; dly_max = 2; rdy_rand = 1'b0;
        run_job(mk(1, 32'h1000, 32'h2000, 32'h3000, 16, 16, 16, 0), 0, 0, 0);
        chk("t1_len", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            chk("t1_op0", acc_log[0].op, 0); chk("t1_addr0", acc_log[0].addr, 32'h1000);
            chk("t1_op1", acc_log[1].op, 1); chk("t1_addr1", acc_log[1].addr, 32'h2000);
            chk("t1_op2", acc_log[2].op, 2); chk("t1_clr2", acc_log[2].acc_clr, 1);
            chk("t1_op3", acc_log[3].op, 3); chk("t1_addr3", acc_log[3].addr, 32'h3000);
        end

        // 2x2x2 tiles with irq
        dly_min = 1; dly_max = 4;
        run_job(mk(2, 32'h1000, 32'h2000, 32'h3000, 32, 32, 32, 1), 0, 0, 1);
        if (acc_log.size() == 28) begin
            chk("a11_op", acc_log[17].op, 0); chk("a11_addr", acc_log[17].addr, 32'h1210);
            chk("c11_op", acc_log[27].op, 3); chk("c11_addr", acc_log[27].addr, 32'h3840);
        end else chk("t2_len", acc_log.size(), 28);
        pulse_irq_clr();
        @(negedge clk);
        chk("irq_cleared", irq, 0);

        // 10-cycle stall on LOAD_B
        stall_b_arm = 1'b1;
        run_job(rnd_cfg(1, 0), 0, 0, 0);
        chk("stall_cycles", stall_cnt, 10);

        // abort in WAIT after third command
        dly_min = 3; dly_max = 4;
        start_job(mk(2, 32'h1000, 32'h2000, 32'h3000, 32, 32, 32, 1));
        cyc = 0;
        while (acc_log.size() < 3 && cyc < 200) begin @(negedge clk); cyc++; end
        chk("abort_reached_3rd", (acc_log.size() >= 3), 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", cmd_valid, 0);
        valid_cnt = 0;
        repeat (20) @(negedge clk);
        chk("abort_no_valid", valid_cnt, 0);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_irq", irq, 0);
        exp_q.delete();
        dly_min = 1; dly_max = 4;
        run_job(rnd_cfg(2, 0), 0, 0, 0);

        // zero-tile job sets irq; then mid-job start with irq_clr colliding with done
        run_job(rnd_cfg(0, 1), 0, 0, 1);
        pulse_irq_clr();
        rdy_rand = 1'b1;
        run_job(rnd_cfg(2, 1), 1, 1, 1);
        pulse_irq_clr();

        // randomized jobs
        for (int r = 0; r < 4; r++) begin
            bit ie;
            ie = ($urandom_range(0, 1) == 1);
            run_job(rnd_cfg(int'($urandom_range(1, 3)), ie), 0, 0, ie);
            pulse_irq_clr();
        end

        // async reset mid-job clears irq and all outputs immediately
        run_job(rnd_cfg(0, 1), 0, 0, 1);
        start_job(rnd_cfg(3, 1));
        cyc = 0;
        while (acc_log.size() < 5 && cyc < 300) begin @(negedge clk); cyc++; end
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        valid_cnt = 0; done_cnt = 0;
        repeat (20) @(negedge clk);
        chk("post_rst_no_valid", valid_cnt, 0);
        chk("post_rst_no_done", done_cnt, 0);
        chk("post_rst_busy", busy, 0);
        run_job(rnd_cfg(2, 0), 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mm_tile_sched.md
Name: mm_tile_sched

Overview:
- Tile-level scheduler for the T x T systolic matrix multiply.
- Takes one job from the register block: base addresses, leading dimensions and tilesK.
- Walks every output tile (i,j) and every K-tile k, issuing a serial command stream to the load/compute/store datapath: LOAD_A, LOAD_B, COMPUTE, and STORE_C at the end of each k sweep.
- Reports completion through done and irq.

Parameters:
- T, mm_pkg::T (16): tile edge in elements.
- W, mm_pkg::W (8): A/B element width in bits; must be a multiple of 8.
- ACCW, mm_pkg::ACCW (32): C element width in bits; must be a multiple of 8.
- CNTW, 16: width of the tile counters i, j, k.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a job (from regs_t.start)
- abort  in  1  one-cycle pulse; cancels the running job
- cfg  in  regs_t  baseA/B/C, lda/ldb/ldc, tilesK, irq_en; sampled at start
- cmd_valid  out  1  command present
- cmd_ready  in  1  datapath accepts command
- cmd_op  out  2  0=LOAD_A 1=LOAD_B 2=COMPUTE 3=STORE_C
- cmd_addr  out  32  byte address of the tile
- cmd_ld  out  16  leading dimension in elements (lda/ldb/ldc; 0 for COMPUTE)
- cmd_acc_clr  out  1  COMPUTE only: clear accumulators (k==0)
- cmd_done  in  1  one-cycle pulse; the accepted command has finished
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- irq  out  1  sticky; set at done when irq_en; cleared by irq_clr
- irq_clr  in  1  clears irq

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Shadow copy of cfg captured on the start cycle; cfg changes mid-job are ignored.
- Loop order: i outer, j middle, k inner; each counter runs 0..tilesK-1.
- States and transitions:
  - IDLE: start -> ISSUE(LOAD_A) with busy=1 the next cycle. If tilesK==0 -> DONE.
  - ISSUE: cmd_valid=1. Fields stay stable until the cmd_valid&&cmd_ready cycle, then -> WAIT.
  - WAIT: cmd_valid=0; wait for cmd_done, then the next op:
    - LOAD_A -> LOAD_B -> COMPUTE.
    - After COMPUTE: k<tilesK-1 -> k++, LOAD_A; otherwise STORE_C.
    - After STORE_C: k=0; advance j (wrapping into i). Last i,j -> DONE.
  - DONE: done=1 for one cycle; busy=0; irq set if irq_en -> IDLE.
- Strictly serial: at most one outstanding command. A cmd_done outside WAIT is ignored.
- Address math is 32-bit, unsigned, wraps modulo 2^32:
  - A(i,k) = baseA + (i*T*lda + k*T)*(W/8)
  - B(k,j) = baseB + (k*T*ldb + j*T)*(W/8)
  - C(i,j) = baseC + (i*T*ldc + j*T)*(ACCW/8)
  - Products are computed combinationally or registered. If registered, cmd_valid must not assert before cmd_addr is valid.
- cmd_acc_clr=1 exactly when op=COMPUTE and k==0.
- start while busy: ignored.
- abort: takes priority over everything in any state -> IDLE next cycle; cmd_valid drops, busy=0, no done, irq unchanged. A late cmd_done in IDLE is ignored.
- Same-cycle abort and start in IDLE: abort wins; no job starts.
- irq_clr and irq set in the same cycle: set wins.
- Async reset mid-job: everything returns to reset values immediately. No done or irq.
- Totals per job (n=tilesK): n^3 LOAD_A, n^3 LOAD_B, n^3 COMPUTE, n^2 STORE_C.

Decomposition:
- Add to mm_pkg:
  - typedef enum logic [1:0] mm_op_e {LOAD_A, LOAD_B, COMPUTE, STORE_C}
  - state enum mm_sched_state_e
  - typedef struct packed mm_cmd_t {op, addr, ld, acc_clr}
  - reuse regs_t and existing parameters.
- One natural sub-module, mm_tile_addr_gen: combinational or 1-stage tile-address calculator driven by op, i, j, k and the cfg shadow.

Test Plan:
- tilesK=1, baseA=0x1000, baseB=0x2000, baseC=0x3000, ld*=16, cmd_ready=1, cmd_done 2 cycles after accept -> exact sequence LOAD_A@0x1000, LOAD_B@0x2000, COMPUTE(acc_clr=1), STORE_C@0x3000; then one done pulse; busy low.
- tilesK=2 (N=32), ld*=32, irq_en=1:
  - counts are 8 LOAD_A, 8 LOAD_B, 8 COMPUTE (4 with acc_clr), 4 STORE_C;
  - A(1,1)=0x1210, C(1,1)=0x3840;
  - irq=1 after done, cleared by irq_clr.
- cmd_ready held low 10 cycles during LOAD_B -> cmd_valid and all fields stable for all 10 cycles; exactly one accept.
- abort pulsed in WAIT after the third command -> IDLE next cycle; no done; irq=0. A subsequent start runs a full job correctly.
- tilesK=0 start -> done 2 cycles after start; zero cmd_valid cycles. Also: start pulse mid-job has no effect on counts.
- rst_n asserted mid-job -> all outputs 0 asynchronously; after release, idle until the next start.
